// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand stage and the ALU itself.
//   - ALUOp encodings (add/sub/sll/srl), consumed by both blocks
//   - operand-stage occupancy state encoding
//   - default widths
//   - helper that identifies shift operations
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int TAG_W_DEF   = 5;
  localparam int SHAMT_W_DEF = 5;
  localparam int CNT_W_DEF   = 16;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_SLL = 2'b10;
  localparam logic [1:0] ALUOP_SRL = 2'b11;

  // Occupancy of the operand stage: nothing, main entry only, main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Shift operations carry a shift amount in B rather than a full operand.
  function automatic logic is_shift(input logic [1:0] op);
    return (op == ALUOP_SLL) || (op == ALUOP_SRL);
  endfunction

endpackage

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Pipeline stage in front of the ALU. Accepts decoded operand sets with a
// valid/ready handshake and presents them, held stable, on the ALU inputs.
// A two-entry buffer (main + skid) lets in_ready be a plain register: when
// the main entry is stalled, one more entry can still land in the skid slot.
// Shift amounts are trimmed to SHAMT_W bits on capture, and cycles spent
// stalled by the ALU are counted in a saturating counter.
//
// Ports
//   Clk        clock, all state changes on the rising edge
//   Reset      synchronous active-high reset (clears everything)
//   Flush      synchronous flush: empties the stage, keeps StallCnt
//   in_valid   upstream has an operand set
//   in_ready   stage accepts this cycle (registered)
//   in_ALUOp   operation (add/sub/sll/srl)
//   in_A       operand A
//   in_B       operand B or shift amount
//   in_rd      destination tag
//   out_valid  ALUOp/A/B/rd carry a valid operation
//   out_ready  ALU/writeback consumes this cycle
//   ALUOp,A,B  operation and operands to the ALU
//   rd         destination tag, travels with the result
//   StallCnt   saturating count of cycles with out_valid & !out_ready
// ---------------------------------------------------------------------------
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_ALUOp,
  input  logic [DATA_W-1:0] in_A,
  input  logic [DATA_W-1:0] in_B,
  input  logic [TAG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        ALUOp,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [TAG_W-1:0]  rd,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state_reg;
  state_t state_next;

  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  // Main entry: drives the ALU inputs directly.
  logic [1:0]        main_op_reg;
  logic [DATA_W-1:0] main_a_reg;
  logic [DATA_W-1:0] main_b_reg;
  logic [TAG_W-1:0]  main_rd_reg;

  // Skid entry: holds the set accepted while main was stalled.
  logic [1:0]        skid_op_reg;
  logic [DATA_W-1:0] skid_a_reg;
  logic [DATA_W-1:0] skid_b_reg;
  logic [TAG_W-1:0]  skid_rd_reg;

  logic              accept;
  logic              issue;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic [DATA_W-1:0] b_capture;

  // Handshakes are qualified by registered flags only, so in_ready never
  // depends on out_ready in the same cycle.
  assign accept = in_valid & in_ready_reg;
  assign issue  = out_valid_reg & out_ready;

  // Shift ops keep only the low SHAMT_W bits of B; add/sub pass B through.
  assign b_capture = is_shift(in_ALUOp)
                   ? {{(DATA_W-SHAMT_W){1'b0}}, in_B[SHAMT_W-1:0]}
                   : in_B;

  // Next occupancy and which data registers load this edge.
  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (Flush) begin
      // A same-cycle accept is dropped: no load strobes asserted.
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next   = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && issue) begin
            // Main drains and refills on the same edge.
            load_main_in = 1'b1;
          end else if (accept) begin
            state_next = ST_FULL;
            load_skid  = 1'b1;
          end else if (issue) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the skid-to-main move can happen.
          if (issue) begin
            state_next     = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      stall_cnt_reg <= '0;
      main_op_reg   <= '0;
      main_a_reg    <= '0;
      main_b_reg    <= '0;
      main_rd_reg   <= '0;
      skid_op_reg   <= '0;
      skid_a_reg    <= '0;
      skid_b_reg    <= '0;
      skid_rd_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      // Flags are derived from the next occupancy so they line up with it.
      in_ready_reg  <= (state_next != ST_FULL);
      out_valid_reg <= (state_next != ST_EMPTY);

      // Stall counting is independent of Flush.
      if (out_valid_reg && !out_ready && (stall_cnt_reg != CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end

      if (load_main_in) begin
        main_op_reg <= in_ALUOp;
        main_a_reg  <= in_A;
        main_b_reg  <= b_capture;
        main_rd_reg <= in_rd;
      end else if (load_main_skid) begin
        main_op_reg <= skid_op_reg;
        main_a_reg  <= skid_a_reg;
        main_b_reg  <= skid_b_reg;
        main_rd_reg <= skid_rd_reg;
      end

      if (load_skid) begin
        skid_op_reg <= in_ALUOp;
        skid_a_reg  <= in_A;
        skid_b_reg  <= b_capture;
        skid_rd_reg <= in_rd;
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign ALUOp     = main_op_reg;
  assign A         = main_a_reg;
  assign B         = main_b_reg;
  assign rd        = main_rd_reg;
  assign StallCnt  = stall_cnt_reg;

endmodule
